// File: rtl/mmcm_phase_ctrl.sv
// mmcm_phase_ctrl: MMCM reset/lock sequencer and fine-phase-shift stepper.
// Runs the MMCM reset sequence, waits for lock, then walks the applied phase
// one PSEN step at a time toward a host-written signed target.
// Optional psdone watchdog: define MMCM_PS_TIMEOUT_EN.
module mmcm_phase_ctrl #(
    parameter int PHASE_WIDTH    = 8,
    parameter int RST_CYCLES     = 16,
    parameter int PSDONE_TIMEOUT = 63
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mmcm_rst_req,
    input  logic                   ps_we,
    input  logic [PHASE_WIDTH-1:0] ps_target,
    output logic [PHASE_WIDTH-1:0] ps_cur,
    output logic                   ps_rdy,
    output logic                   ps_err,
    output logic                   mmcm_rst,
    input  logic                   mmcm_locked,
    output logic                   psen,
    output logic                   psincdec,
    input  logic                   psdone
);

    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RST_CYCLES - 1);
    localparam logic signed [PHASE_WIDTH-1:0] ONE = 1;

    typedef enum logic [2:0] {
        S_RST_MMCM,
        S_WAIT_LOCK,
        S_IDLE,
        S_STEP,
        S_WAIT_DONE
    } state_t;

    state_t                        state_q;
    logic [CNT_W-1:0]              cnt_q;
    logic signed [PHASE_WIDTH-1:0] ps_cur_q;
    logic signed [PHASE_WIDTH-1:0] target_q;
    logic signed [PHASE_WIDTH-1:0] ps_cur_d;
    logic                          mmcm_rst_q;
    logic                          psen_q;
    logic                          psincdec_q;

`ifdef MMCM_PS_TIMEOUT_EN
    localparam int WD_W = $clog2(PSDONE_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(PSDONE_TIMEOUT - 1);
    logic [WD_W-1:0] wd_q;
    logic            ps_err_q;
`endif

    // Target register: written in any state, survives MMCM reset sequences.
    always_ff @(posedge clk) begin
        if (rst) begin
            target_q <= '0;
        end else if (ps_we) begin
            target_q <= ps_target;
        end
    end

    // Phase after the in-flight step completes, in the held direction.
    always_comb begin
        ps_cur_d = psincdec_q ? (ps_cur_q + ONE) : (ps_cur_q - ONE);
    end

    // Sequencer: reset/lock, step issue, psdone wait, lock-loss recovery.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RST_MMCM;
            cnt_q      <= CNT_INIT;
            mmcm_rst_q <= 1'b1;
            ps_cur_q   <= '0;
            psen_q     <= 1'b0;
            psincdec_q <= 1'b0;
`ifdef MMCM_PS_TIMEOUT_EN
            wd_q       <= '0;
            ps_err_q   <= 1'b0;
`endif
        end else begin
            psen_q <= 1'b0;
`ifdef MMCM_PS_TIMEOUT_EN
            if (mmcm_rst_req) begin
                ps_err_q <= 1'b0;
            end
`endif
            case (state_q)
                S_RST_MMCM: begin
                    mmcm_rst_q <= 1'b1;
                    ps_cur_q   <= '0;
                    if (cnt_q == '0) begin
                        state_q    <= S_WAIT_LOCK;
                        mmcm_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (mmcm_locked) begin
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (mmcm_rst_req || !mmcm_locked) begin
                        state_q    <= S_RST_MMCM;
                        cnt_q      <= CNT_INIT;
                        mmcm_rst_q <= 1'b1;
                        ps_cur_q   <= '0;
                    end else if (target_q != ps_cur_q) begin
                        state_q    <= S_STEP;
                        psen_q     <= 1'b1;
                        psincdec_q <= (target_q > ps_cur_q);
                    end
                end
                S_STEP: begin
                    state_q <= S_WAIT_DONE;
`ifdef MMCM_PS_TIMEOUT_EN
                    wd_q    <= '0;
`endif
                end
                S_WAIT_DONE: begin
                    if (psdone) begin
                        ps_cur_q <= ps_cur_d;
                        state_q  <= S_IDLE;
                    end else if (mmcm_rst_req || !mmcm_locked) begin
                        // The MMCM is being reset, so the pending step is lost.
                        state_q    <= S_RST_MMCM;
                        cnt_q      <= CNT_INIT;
                        mmcm_rst_q <= 1'b1;
                        ps_cur_q   <= '0;
                    end
`ifdef MMCM_PS_TIMEOUT_EN
                    else if (wd_q == WD_LAST) begin
                        ps_err_q   <= 1'b1;
                        state_q    <= S_RST_MMCM;
                        cnt_q      <= CNT_INIT;
                        mmcm_rst_q <= 1'b1;
                        ps_cur_q   <= '0;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q    <= S_RST_MMCM;
                    cnt_q      <= CNT_INIT;
                    mmcm_rst_q <= 1'b1;
                    ps_cur_q   <= '0;
                end
            endcase
        end
    end

    assign ps_cur   = ps_cur_q;
    assign mmcm_rst = mmcm_rst_q;
    assign psen     = psen_q;
    assign psincdec = psincdec_q;
    assign ps_rdy   = (state_q == S_IDLE) & mmcm_locked & (target_q == ps_cur_q) & ~ps_we;

`ifdef MMCM_PS_TIMEOUT_EN
    assign ps_err = ps_err_q;
`else
    // No watchdog in this build; the expression is constant 0.
    assign ps_err = (PSDONE_TIMEOUT < 0);
`endif

endmodule
